display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Scheduler for the shared seven-segment decoder: time-multiplexes up to NUM_DIGITS 4-bit values onto one decoder input and drives one active-low common-anode enable per digit. A blanking interval between digits (all enables off) prevents ghosting, and a per-digit mask skips unused digits. It sits between the switch/adder logic that produces digit values and the seven-segment decoder/output pins, replacing free-running two-digit toggling.

## Interface
Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (2..8)
- DWELL_CYCLES, 24000, clk cycles a digit is driven (>=1)
- BLANK_CYCLES, 240, clk cycles all digits are off between digits (>=1)

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- digits_in  input  4*NUM_DIGITS  digit k value at bits [4k+3:4k]
- digit_mask  input  NUM_DIGITS  1 = digit k participates in scan
- sev_seg_value  output  4  value to the seven-segment decoder
- digit_en_n  output  NUM_DIGITS  active-low digit enables; at most one low
- active_digit  output  $clog2(NUM_DIGITS)  index currently or next driven
- frame_tick  output  1  one-cycle pulse when the scan wraps to the lowest enabled digit

## Operation
- States: IDLE, BLANK, DRIVE (scan_state_t).
- Reset (sampled on a rising edge with reset=1): state IDLE, counter 0, active_digit 0, sev_seg_value 4'h0, digit_en_n all 1s, frame_tick 0.
- IDLE: all enables high. If digit_mask != 0, next state BLANK, active_digit = lowest set mask bit, counter loaded with BLANK_CYCLES-1.
- BLANK: all enables high; counts down; at count 0, next state DRIVE, counter loaded with DWELL_CYCLES-1, sev_seg_value latched from digits_in[active_digit].
- DRIVE: digit_en_n[active_digit]=0, others 1; sev_seg_value held (value changes on digits_in are not visible until that digit's next DRIVE). At count 0: next state BLANK with active_digit = next set mask bit strictly above current, wrapping to the lowest set bit.
- Wrap: when the selected next index is <= current (including a single enabled digit selecting itself), frame_tick pulses in the first BLANK cycle.
- Mask changes: sampled every cycle. If digit_mask becomes 0 in any state, next state IDLE (enables off next cycle). If the active digit's mask bit clears during DRIVE, DRIVE ends early: next state BLANK with normal next-digit selection. Mask changes during BLANK re-evaluate the target at BLANK exit: if the pending digit is now disabled, select the next enabled one above it (wrapping).
- Reset mid-scan: returns to IDLE on the same edge regardless of state; no partial dwell is completed.

## Timing
- All outputs registered; Moore outputs derived from state register.
- From reset release with nonzero mask: edge 1 enters BLANK, DRIVE begins at edge 1+BLANK_CYCLES.
- Per-digit period = BLANK_CYCLES + DWELL_CYCLES cycles; frame period = period x number of enabled digits.
- digit_en_n low for exactly DWELL_CYCLES consecutive cycles per visit (unless shortened by mask clear); never two digits low, never low in the same cycle as a digit change.
- Counter width $clog2(max(DWELL_CYCLES, BLANK_CYCLES)); no overflow possible, counter only counts down to 0.

## Structure
- Package display_pkg: scan_state_t enum, DIGIT_W = 4 constant, default DWELL/BLANK constants for the 48 MHz clock.
- One sub-module: next_digit_finder (combinational, parameter NUM_DIGITS): given mask and current index, returns next set index above current with wrap, plus a wrapped flag and a none-set flag. Used both at DRIVE exit and BLANK re-evaluation.

## Test plan
Bench parameters NUM_DIGITS=2, DWELL_CYCLES=4, BLANK_CYCLES=1.
- Reset, mask=2'b11, digits_in=8'h82 -> edge 1 BLANK (en=2'b11); edges 2-5 en=2'b10, value=4'h2; edge 6 en=2'b11; edges 7-10 en=2'b01, value=4'h8; frame_tick high at edge 11 only.
- Change digits_in to 8'hF0 mid-DRIVE of digit 0 -> value stays 4'h2 until that dwell ends; digit 1 then shows 4'hF, next digit 0 visit shows 4'h0.
- mask=2'b10 -> only digit 1 driven, en alternates 2'b11 (1 cycle) / 2'b01 (4 cycles), frame_tick every 5 cycles.
- Clear mask bit 0 during digit 0's second DRIVE cycle -> en=2'b11 next cycle, then digit 1 driven.
- mask=2'b00 mid-DRIVE -> IDLE next edge, en=2'b11 held; mask=2'b01 restores scan with BLANK then digit 0.
- Assert reset during DRIVE -> next edge en=2'b11, value=4'h0, active_digit=0, frame_tick=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  // Width of one BCD/hex digit value presented to the decoder.
  localparam int DIGIT_W = 4;

  // Defaults for a 48 MHz clock: 0.5 ms dwell, 5 us blanking.
  localparam int DEFAULT_DWELL_CYCLES = 24000;
  localparam int DEFAULT_BLANK_CYCLES = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Down-counter width able to hold the larger of the two reload values.
  // Never narrower than one bit so single-cycle phases still elaborate.
  function automatic int counter_width(input int dwell, input int blank);
    int m;
    int w;
    m = (dwell > blank) ? dwell : blank;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational search for the next enabled digit strictly above the
// current index, wrapping to the lowest enabled digit when none is above.
module next_digit_finder #(
  parameter int NUM_DIGITS = 2,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  input  logic [IDX_W-1:0]      cur,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  wrapped,
  output logic                  none_set
);

  logic [NUM_DIGITS-1:0] above_mask;
  logic [IDX_W-1:0]      above_idx;
  logic                  above_found;
  logic [IDX_W-1:0]      low_idx;

  // Enabled digits whose index is strictly greater than the current one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_above
      assign above_mask[gi] = mask[gi] && (IDX_W'(gi) > cur);
    end
  endgenerate

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    above_idx   = '0;
    above_found = 1'b0;
    low_idx     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (above_mask[i]) begin
        above_idx   = IDX_W'(i);
        above_found = 1'b1;
      end
      if (mask[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign next_idx = above_found ? above_idx : low_idx;
  assign wrapped  = ~above_found;
  assign none_set = ~|mask;

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes up to NUM_DIGITS digit values onto one seven-segment
// decoder, with a blanking gap between digits and a per-digit enable mask.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  output logic [DIGIT_W-1:0]            sev_seg_value,
  output logic [NUM_DIGITS-1:0]         digit_en_n,
  output logic [IDX_W-1:0]              active_digit,
  output logic                          frame_tick
);

  localparam int CNT_W = counter_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t           state_reg, state_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [IDX_W-1:0]      active_reg, active_next;
  logic [DIGIT_W-1:0]    value_reg, value_next;
  logic [NUM_DIGITS-1:0] en_reg, en_next;
  logic                  tick_reg, tick_next;

  logic [DIGIT_W-1:0]    digit_val [NUM_DIGITS];
  logic [IDX_W-1:0]      low_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  wrapped;
  logic                  none_set;
  logic [IDX_W-1:0]      blank_target;

  // Unpack the flat digit bus into one entry per digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_val[gi] = digits_in[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  // Successor of the active digit; serves both DRIVE exit and the
  // re-check of a pending digit that was disabled while blanking.
  next_digit_finder #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_finder (
    .mask     (digit_mask),
    .cur      (active_reg),
    .next_idx (next_idx),
    .wrapped  (wrapped),
    .none_set (none_set)
  );

  // Lowest enabled digit, used when a scan starts from IDLE.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // If the pending digit lost its mask bit during BLANK, move on to its successor.
  assign blank_target = digit_mask[active_reg] ? active_reg : next_idx;

  // Next-state and next-output logic; outputs are registered alongside state.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    active_next = active_reg;
    value_next  = value_reg;
    en_next     = '1;
    tick_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!none_set) begin
          state_next  = BLANK;
          active_next = low_idx;
          count_next  = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (count_reg == '0) begin
          state_next  = DRIVE;
          count_next  = DWELL_LOAD;
          active_next = blank_target;
          value_next  = digit_val[blank_target];
          en_next     = ~(NUM_DIGITS'(1) << blank_target);
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!digit_mask[active_reg] || count_reg == '0) begin
          // Dwell finished or the digit was disabled under us.
          state_next  = BLANK;
          count_next  = BLANK_LOAD;
          active_next = next_idx;
          tick_next   = wrapped;
        end else begin
          count_next = count_reg - CNT_W'(1);
          en_next    = ~(NUM_DIGITS'(1) << active_reg);
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase

    // An empty mask parks the scanner regardless of where it was.
    if (none_set) begin
      state_next  = IDLE;
      count_next  = '0;
      active_next = active_reg;
      value_next  = value_reg;
      en_next     = '1;
      tick_next   = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      active_reg <= '0;
      value_reg  <= '0;
      en_reg     <= '1;
      tick_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      active_reg <= active_next;
      value_reg  <= value_next;
      en_reg     <= en_next;
      tick_reg   <= tick_next;
    end
  end

  assign sev_seg_value = value_reg;
  assign digit_en_n    = en_reg;
  assign active_digit  = active_reg;
  assign frame_tick    = tick_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus a randomized
// run checked against a phase/time-based reference model.
module tb_display_scan_controller;

  localparam int N     = 2;
  localparam int DWELL = 4;
  localparam int BLANK = 1;

  logic         clk;
  logic         reset;
  logic [7:0]   digits_in;
  logic [1:0]   digit_mask;
  logic [3:0]   sev_seg_value;
  logic [1:0]   digit_en_n;
  logic [0:0]   active_digit;
  logic         frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase (0 idle, 1 blank, 2 drive), cycles spent in phase.
  int         m_mode    = 0;
  int         m_elapsed = 0;
  int         m_digit   = 0;
  logic [3:0] m_shown   = 4'h0;
  logic       m_tick    = 1'b0;

  display_scan_controller #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .digits_in     (digits_in),
    .digit_mask    (digit_mask),
    .sev_seg_value (sev_seg_value),
    .digit_en_n    (digit_en_n),
    .active_digit  (active_digit),
    .frame_tick    (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest_enabled(input logic [1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) return i;
    end
    return 0;
  endfunction

  // Walk forward modulo N from cur; wrap means we landed at or below cur.
  task automatic find_next(input int cur, input logic [1:0] mask,
                           output int nd, output bit wr);
    nd = cur;
    wr = 1'b1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (cur + k) % N;
      if (mask[idx]) begin
        nd = idx;
        wr = (idx <= cur);
        break;
      end
    end
  endtask

  function automatic logic [1:0] exp_en();
    logic [1:0] one;
    one = 2'b01;
    return (m_mode == 2) ? ~(one << m_digit) : 2'b11;
  endfunction

  task automatic model_update();
    int nd;
    bit wr;
    m_tick = 1'b0;
    if (reset) begin
      m_mode = 0; m_elapsed = 0; m_digit = 0; m_shown = 4'h0;
    end else if (digit_mask == 2'b00) begin
      m_mode = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: begin
          m_mode = 1; m_elapsed = 0; m_digit = lowest_enabled(digit_mask);
        end
        1: begin
          if (m_elapsed + 1 >= BLANK) begin
            if (!digit_mask[m_digit]) begin
              find_next(m_digit, digit_mask, nd, wr);
              m_digit = nd;
            end
            m_shown = digits_in[m_digit*4 +: 4];
            m_mode = 2; m_elapsed = 0;
          end else begin
            m_elapsed++;
          end
        end
        default: begin
          if (!digit_mask[m_digit] || m_elapsed + 1 >= DWELL) begin
            find_next(m_digit, digit_mask, nd, wr);
            m_tick = wr; m_digit = nd; m_mode = 1; m_elapsed = 0;
          end else begin
            m_elapsed++;
          end
        end
      endcase
    end
  endtask

  // Advance one clock edge (model follows the same inputs); sample 1 ns later.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; digit_mask = 2'b11; digits_in = 8'h82;
    step(); step();
    checks++;
    if ({digit_en_n, sev_seg_value, active_digit, frame_tick} !== {2'b11, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: en=%b val=%h act=%0d tick=%b required en=11 val=0 act=0 tick=0",
               digit_en_n, sev_seg_value, active_digit, frame_tick);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [1:0] en_tbl  [11];
    logic [3:0] val_tbl [11];
    logic       act_tbl [11];
    en_tbl  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    val_tbl = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
    act_tbl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int e = 1; e <= 11; e++) begin
      step();
      checks++;
      if (digit_en_n !== en_tbl[e-1] || sev_seg_value !== val_tbl[e-1] ||
          active_digit !== act_tbl[e-1] || frame_tick !== (e == 11)) begin
        failures++;
        $display("FAIL basic_scan edge %0d: en=%b val=%h act=%0d tick=%b required en=%b val=%h act=%0d tick=%b",
                 e, digit_en_n, sev_seg_value, active_digit, frame_tick,
                 en_tbl[e-1], val_tbl[e-1], act_tbl[e-1], (e == 11));
      end
    end
  endtask

  // Continues from edge 11 of the basic scan.
  task automatic test_value_hold();
    step(); step();                 // edges 12, 13: digit 0 driving
    digits_in = 8'hF0;
    for (int e = 14; e <= 15; e++) begin
      step();
      checks++;
      if (digit_en_n !== 2'b10 || sev_seg_value !== 4'h2) begin
        failures++;
        $display("FAIL value_hold edge %0d: en=%b val=%h required en=10 val=2",
                 e, digit_en_n, sev_seg_value);
      end
    end
    step();                         // edge 16: blank
    step();                         // edge 17: digit 1
    checks++;
    if (digit_en_n !== 2'b01 || sev_seg_value !== 4'hF) begin
      failures++;
      $display("FAIL value_new_d1: en=%b val=%h required en=01 val=f", digit_en_n, sev_seg_value);
    end
    for (int e = 18; e <= 22; e++) step();
    checks++;
    if (digit_en_n !== 2'b10 || sev_seg_value !== 4'h0) begin
      failures++;
      $display("FAIL value_new_d0: en=%b val=%h required en=10 val=0", digit_en_n, sev_seg_value);
    end
  endtask

  task automatic test_single_digit();
    digit_mask = 2'b10;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      logic [1:0] en_x;
      logic       tick_x;
      step();
      en_x   = ((e - 1) % 5 == 0) ? 2'b11 : 2'b01;
      tick_x = ((e - 1) % 5 == 0) && (e > 1);
      checks++;
      if (digit_en_n !== en_x || frame_tick !== tick_x || active_digit !== 1'b1) begin
        failures++;
        $display("FAIL single_digit edge %0d: en=%b tick=%b act=%0d required en=%b tick=%b act=1",
                 e, digit_en_n, frame_tick, active_digit, en_x, tick_x);
      end
    end
  endtask

  task automatic test_mask_clear_drive();
    digit_mask = 2'b11;
    digits_in  = 8'h5A;
    do_reset();
    step(); step(); step();         // edge 3: digit 0 second DRIVE cycle
    digit_mask = 2'b10;
    step();
    checks++;
    if (digit_en_n !== 2'b11 || active_digit !== 1'b1 || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL mask_clear_blank: en=%b act=%0d tick=%b required en=11 act=1 tick=0",
               digit_en_n, active_digit, frame_tick);
    end
    step();
    checks++;
    if (digit_en_n !== 2'b01 || sev_seg_value !== 4'h5) begin
      failures++;
      $display("FAIL mask_clear_next: en=%b val=%h required en=01 val=5", digit_en_n, sev_seg_value);
    end
  endtask

  task automatic test_mask_zero();
    logic [7:0] d;
    d = 8'($urandom);
    digits_in  = d;
    digit_mask = 2'b11;
    do_reset();
    step(); step(); step();
    digit_mask = 2'b00;
    for (int e = 4; e <= 7; e++) begin
      step();
      checks++;
      if (digit_en_n !== 2'b11 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL mask_zero edge %0d: en=%b tick=%b required en=11 tick=0", e, digit_en_n, frame_tick);
      end
    end
    digit_mask = 2'b01;
    step();
    checks++;
    if (digit_en_n !== 2'b11 || active_digit !== 1'b0) begin
      failures++;
      $display("FAIL mask_restore_blank: en=%b act=%0d required en=11 act=0", digit_en_n, active_digit);
    end
    step();
    checks++;
    if (digit_en_n !== 2'b10 || sev_seg_value !== d[3:0]) begin
      failures++;
      $display("FAIL mask_restore_drive: en=%b val=%h required en=10 val=%h", digit_en_n, sev_seg_value, d[3:0]);
    end
  endtask

  task automatic test_reset_mid_drive();
    digit_mask = 2'b11;
    digits_in  = 8'($urandom) | 8'h11;
    do_reset();
    for (int e = 1; e <= 8; e++) step();
    checks++;
    if (digit_en_n !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset_drive: en=%b required en=01", digit_en_n);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({digit_en_n, sev_seg_value, active_digit, frame_tick} !== {2'b11, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_drive: en=%b val=%h act=%0d tick=%b required en=11 val=0 act=0 tick=0",
               digit_en_n, sev_seg_value, active_digit, frame_tick);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    digit_mask = 2'b11;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) digit_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  digits_in  = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if (digit_en_n !== exp_en() || sev_seg_value !== m_shown ||
          active_digit !== 1'(m_digit) || frame_tick !== m_tick) begin
        failures++;
        $display("FAIL random cycle %0d: en=%b val=%h act=%0d tick=%b required en=%b val=%h act=%0d tick=%b",
                 c, digit_en_n, sev_seg_value, active_digit, frame_tick,
                 exp_en(), m_shown, m_digit, m_tick);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; digit_mask = 2'b00; digits_in = 8'h00;
    test_reset();
    test_basic_scan();
    test_value_hold();
    test_single_digit();
    test_mask_clear_drive();
    test_mask_zero();
    test_reset_mid_drive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
